// File: rtl/vid_sof_detect.sv
// vid_sof_detect: passive AXI4-Stream video tap monitor emitting a decimated frame sync pulse and frame geometry
// clk, resetn       : clock, asynchronous active-low reset
// enable            : allows sync_pulse generation (measurement always runs)
// s_tvalid/s_tready : tapped handshake, a beat is both high
// s_tuser/s_tlast   : start-of-frame and end-of-line markers, qualified by a beat
// sync_pulse        : one-cycle pulse on every SYNC_DIV-th enabled SOF
// line_width        : beats per line of the last complete frame
// frame_height      : lines in the last complete frame
// geom_valid        : last complete frame was well-formed
// err_pulse         : one-cycle pulse whenever a new error bit is raised
// err_code          : sticky {overflow, sof mid-line, line length mismatch}, restarted at each SOF
module vid_sof_detect #(
    parameter int W_BITS   = 13,
    parameter int H_BITS   = 12,
    parameter int SYNC_DIV = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              enable,
    input  logic              s_tvalid,
    input  logic              s_tready,
    input  logic              s_tuser,
    input  logic              s_tlast,
    output logic              sync_pulse,
    output logic [W_BITS-1:0] line_width,
    output logic [H_BITS-1:0] frame_height,
    output logic              geom_valid,
    output logic              err_pulse,
    output logic [2:0]        err_code
);
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t            state;
    logic [W_BITS-1:0] px_cnt;
    logic [W_BITS-1:0] ref_width;
    logic [H_BITS-1:0] line_cnt;
    logic [7:0]        div_cnt;
    logic              beat;
    logic              px_max;
    logic              line_max;
    logic              sof_err;
    logic [W_BITS-1:0] len;
    logic [2:0]        run_err;
    assign beat     = s_tvalid & s_tready;
    assign px_max   = &px_cnt;
    assign line_max = &line_cnt;
    // saturating beat count including the current beat
    assign len      = px_max ? px_cnt : px_cnt + 1'b1;
    assign sof_err  = (state == ACTIVE) && (px_cnt != '0);
    assign run_err  = {px_max | (s_tlast & line_max), 1'b0,
                       s_tlast && (line_cnt != '0) && (len != ref_width)};
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            px_cnt       <= '0;
            ref_width    <= '0;
            line_cnt     <= '0;
            div_cnt      <= '0;
            sync_pulse   <= 1'b0;
            line_width   <= '0;
            frame_height <= '0;
            geom_valid   <= 1'b0;
            err_pulse    <= 1'b0;
            err_code     <= '0;
        end else begin
            sync_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            if (beat && s_tuser) begin
                if (state == ACTIVE) begin
                    frame_height <= line_cnt;
                    line_width   <= ref_width;
                    // err_code[1] here belongs to the SOF that opened this frame, not to the frame itself
                    geom_valid   <= !sof_err && !err_code[0] && !err_code[2] &&
                                    (line_cnt != '0) && (ref_width != '0);
                    err_pulse    <= sof_err;
                end
                state     <= ACTIVE;
                err_code  <= {1'b0, sof_err, 1'b0};
                px_cnt    <= s_tlast ? '0 : W_BITS'(1);
                line_cnt  <= s_tlast ? H_BITS'(1) : '0;
                ref_width <= s_tlast ? W_BITS'(1) : '0;
                if (enable) begin
                    sync_pulse <= (div_cnt == '0);
                    div_cnt    <= (div_cnt == 8'(SYNC_DIV - 1)) ? '0 : div_cnt + 1'b1;
                end
            end else if (beat && state == ACTIVE) begin
                err_code  <= err_code | run_err;
                err_pulse <= |(run_err & ~err_code);
                if (s_tlast) begin
                    px_cnt   <= '0;
                    line_cnt <= line_max ? line_cnt : line_cnt + 1'b1;
                    if (line_cnt == '0)
                        ref_width <= len;
                end else begin
                    px_cnt <= len;
                end
            end
        end
    end
endmodule

// File: tb/tb_vid_sof_detect.sv
// tb_vid_sof_detect: randomized check of three vid_sof_detect variants against a frame-level reference model
module tb_vid_sof_detect;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        enable = 1'b1;
    logic        s_tvalid = 1'b0;
    logic        s_tready = 1'b0;
    logic        s_tuser = 1'b0;
    logic        s_tlast = 1'b0;
    logic [2:0]  sync_v, gv_v, errp_v;
    logic [12:0] lw0, lw1;
    logic [2:0]  lw2;
    logic [11:0] fh0, fh1;
    logic [1:0]  fh2;
    logic [2:0]  ec0, ec1, ec2;
    int          g_sync[3], g_errp[3], g_lw[3], g_fh[3], g_gv[3], g_ec[3];
    int          wb[3] = '{13, 13, 3};
    int          hb[3] = '{12, 12, 2};
    int          dv[3] = '{1, 3, 1};
    int          e_sync[3], e_errp[3], e_lw[3], e_fh[3], e_gv[3];
    bit          inf[3], mid[3], mm[3], lovf[3];
    int          cur[3], nlines[3], first[3], sofs[3];
    int          checks = 0;
    int          errors = 0;
    bit          en = 1'b1;

    always #5 clk = ~clk;

    vid_sof_detect #(.W_BITS(13), .H_BITS(12), .SYNC_DIV(1)) u0 (
        .clk(clk), .resetn(resetn), .enable(enable), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tuser(s_tuser), .s_tlast(s_tlast), .sync_pulse(sync_v[0]), .line_width(lw0),
        .frame_height(fh0), .geom_valid(gv_v[0]), .err_pulse(errp_v[0]), .err_code(ec0));
    vid_sof_detect #(.W_BITS(13), .H_BITS(12), .SYNC_DIV(3)) u1 (
        .clk(clk), .resetn(resetn), .enable(enable), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tuser(s_tuser), .s_tlast(s_tlast), .sync_pulse(sync_v[1]), .line_width(lw1),
        .frame_height(fh1), .geom_valid(gv_v[1]), .err_pulse(errp_v[1]), .err_code(ec1));
    vid_sof_detect #(.W_BITS(3), .H_BITS(2), .SYNC_DIV(1)) u2 (
        .clk(clk), .resetn(resetn), .enable(enable), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tuser(s_tuser), .s_tlast(s_tlast), .sync_pulse(sync_v[2]), .line_width(lw2),
        .frame_height(fh2), .geom_valid(gv_v[2]), .err_pulse(errp_v[2]), .err_code(ec2));

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            g_sync[i] = int'(sync_v[i]);
            g_errp[i] = int'(errp_v[i]);
            g_gv[i]   = int'(gv_v[i]);
        end
        g_lw[0] = int'(lw0);
        g_lw[1] = int'(lw1);
        g_lw[2] = int'(lw2);
        g_fh[0] = int'(fh0);
        g_fh[1] = int'(fh1);
        g_fh[2] = int'(fh2);
        g_ec[0] = int'(ec0);
        g_ec[1] = int'(ec1);
        g_ec[2] = int'(ec2);
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int min2(input int a, input int b);
        return a < b ? a : b;
    endfunction

    // error bits implied by the current frame's history
    function automatic int ec(input int i);
        bit ovf;
        ovf = lovf[i] || cur[i] >= (1 << wb[i]);
        return (ovf ? 4 : 0) | (mid[i] ? 2 : 0) | (mm[i] ? 1 : 0);
    endfunction

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("sync%0d", i), g_sync[i], e_sync[i]);
            check($sformatf("err_pulse%0d", i), g_errp[i], e_errp[i]);
            check($sformatf("line_width%0d", i), g_lw[i], e_lw[i]);
            check($sformatf("frame_height%0d", i), g_fh[i], e_fh[i]);
            check($sformatf("geom_valid%0d", i), g_gv[i], e_gv[i]);
            check($sformatf("err_code%0d", i), g_ec[i], inf[i] ? ec(i) : 0);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            e_sync[i] = 0; e_errp[i] = 0; e_lw[i] = 0; e_fh[i] = 0; e_gv[i] = 0;
            inf[i] = 0; mid[i] = 0; mm[i] = 0; lovf[i] = 0;
            cur[i] = 0; nlines[i] = 0; first[i] = 0; sofs[i] = 0;
        end
    endtask

    task automatic close_line(input int i);
        if (nlines[i] == 0)
            first[i] = cur[i];
        else if (min2(cur[i], (1 << wb[i]) - 1) != min2(first[i], (1 << wb[i]) - 1))
            mm[i] = 1;
        if (cur[i] >= (1 << wb[i]))
            lovf[i] = 1;
        nlines[i]++;
        if (nlines[i] >= (1 << hb[i]))
            lovf[i] = 1;
        cur[i] = 0;
    endtask

    task automatic model_step(input bit v, input bit r, input bit u, input bit l, input bit e);
        int old;
        bit m;
        for (int i = 0; i < 3; i++) begin
            e_sync[i] = 0;
            e_errp[i] = 0;
            if (v && r && u) begin
                m = inf[i] && cur[i] != 0;
                if (inf[i]) begin
                    old = ec(i);
                    e_fh[i] = min2(nlines[i], (1 << hb[i]) - 1);
                    e_lw[i] = nlines[i] > 0 ? min2(first[i], (1 << wb[i]) - 1) : 0;
                    e_gv[i] = (!m && (old & 5) == 0 && nlines[i] > 0) ? 1 : 0;
                    e_errp[i] = m ? 1 : 0;
                end
                if (e) begin
                    e_sync[i] = (sofs[i] % dv[i] == 0) ? 1 : 0;
                    sofs[i]++;
                end
                inf[i] = 1; mid[i] = m; mm[i] = 0; lovf[i] = 0;
                nlines[i] = 0; first[i] = 0; cur[i] = 1;
                if (l)
                    close_line(i);
            end else if (v && r && inf[i]) begin
                old = ec(i);
                cur[i]++;
                if (l)
                    close_line(i);
                e_errp[i] = ((ec(i) & ~old) != 0) ? 1 : 0;
            end
        end
    endtask

    task automatic cyc(input bit v, input bit r, input bit u, input bit l);
        @(negedge clk);
        compare_all();
        s_tvalid = v; s_tready = r; s_tuser = u; s_tlast = l; enable = en;
        model_step(v, r, u, l, en);
    endtask

    // one beat after random handshake gaps; markers are noise on non-beat cycles
    task automatic send(input bit u, input bit l);
        bit v, r;
        for (int t = 0; t < 8; t++) begin
            v = (t == 7) || ($urandom_range(0, 3) != 0);
            r = (t == 7) || ($urandom_range(0, 3) != 0);
            cyc(v, r, (v && r) ? u : 1'($urandom), (v && r) ? l : 1'($urandom));
            if (v && r)
                break;
        end
    endtask

    task automatic frame(input int n, input int w, input int bad, input int bw);
        for (int ln = 0; ln < n; ln++) begin
            int lw;
            lw = (ln == bad) ? bw : w;
            for (int k = 0; k < lw; k++)
                send(ln == 0 && k == 0, k == lw - 1);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        s_tvalid = 1'b0; s_tready = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
        model_reset();
        #1 compare_all();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();
        repeat (3) frame(4, 8, -1, 0);
        frame(4, 8, 1, 7);
        frame(4, 8, -1, 0);
        frame(4, 8, -1, 0);
        frame(1, 8, -1, 0);
        for (int k = 0; k < 3; k++)
            send(1'b0, 1'b0);
        repeat (2) frame(4, 8, -1, 0);
        repeat (7) frame(1, 2, -1, 0);
        for (int k = 1; k <= 7; k++) begin
            en = !(k == 2 || k == 3);
            frame(2, 3, -1, 0);
        end
        en = 1'b1;
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        send(1'b1, 1'b1);
        send(1'b1, 1'b1);
        frame(2, 9, -1, 0);
        frame(5, 2, -1, 0);
        frame(2, 4, -1, 0);
        frame(3, 6, -1, 0);
        send(1'b0, 1'b0);
        do_reset();
        for (int k = 0; k < 4; k++)
            send(1'b0, k == 2);
        frame(2, 4, -1, 0);
        frame(2, 4, -1, 0);
        for (int f = 0; f < 30; f++) begin
            en = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 4) == 0)
                for (int k = 0; k < int'($urandom_range(1, 3)); k++)
                    send(1'b0, 1'b0);
            frame($urandom_range(1, 5), $urandom_range(1, 10),
                  $urandom_range(0, 2) == 0 ? $urandom_range(0, 4) : -1, $urandom_range(1, 10));
        end
        frame(1, 1, -1, 0);
        @(negedge clk);
        compare_all();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vid_sof_detect.md
Name: vid_sof_detect

Overview:
- Passive monitor on an AXI4-Stream video tap.
- Detects each start-of-frame (SOF) beat and emits a registered single-cycle frame sync pulse, optionally decimated.
- The pulse feeds the downstream sync pulse stretcher that drives frame-rate consumers.
- Also measures line width and frame height, and flags malformed frames.

Parameters:
- W_BITS, 13, width of pixel-per-line counter and line_width output (max 8191 beats/line)
- H_BITS, 12, width of line counter and frame_height output (max 4095 lines/frame)
- SYNC_DIV, 1, sync_pulse emitted on every SYNC_DIV-th accepted SOF (1..255)

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous active-low reset
- enable  input  1  1 = sync_pulse generation allowed; measurement always runs
- s_tvalid  input  1  tapped stream valid
- s_tready  input  1  tapped stream ready (monitor only, never driven)
- s_tuser  input  1  SOF marker, qualified by beat
- s_tlast  input  1  end-of-line marker, qualified by beat
- sync_pulse  output  1  one-cycle frame sync
- line_width  output  W_BITS  beats per line of last complete frame
- frame_height  output  H_BITS  lines in last complete frame
- geom_valid  output  1  last complete frame was well-formed
- err_pulse  output  1  one-cycle pulse on any frame error
- err_code  output  3  sticky error bits [0]=line length mismatch, [1]=SOF mid-line, [2]=counter overflow; cleared at each SOF

Behaviour:
- beat = s_tvalid & s_tready. Without a beat, nothing changes; marker inputs are ignored.
- Reset (async, resetn=0): all outputs 0, state IDLE, all counters 0, div counter 0. Reset mid-frame discards the partial frame.
- States:
  - IDLE: waiting for the first SOF. Non-SOF beats are ignored.
  - ACTIVE: inside a frame.
- SOF beat in IDLE -> ACTIVE:
  - px_cnt = 1, line_cnt = 0, ref_width unset, err_code = 0.
  - No geometry update.
- SOF beat in ACTIVE:
  - Closes the previous frame.
  - If px_cnt != 0 (previous beat not tlast): set err_code[1] and pulse err_pulse.
  - frame_height <= line_cnt; line_width <= ref_width.
  - geom_valid <= 1 only if err_code (including this SOF's bit) is 0, line_cnt != 0 and ref_width != 0; otherwise 0.
  - Then start the new frame as above.
- Non-SOF beat: px_cnt increments.
- tlast beat: line length L = px_cnt_before + 1. px_cnt <= 0; line_cnt increments.
  - First line of frame: ref_width <= L.
  - Later lines: L != ref_width sets err_code[0] and pulses err_pulse.
- Same beat with s_tuser and s_tlast: SOF processing first, then a 1-beat line closes (L = 1, line_cnt = 1).
- Overflow:
  - px_cnt at all-ones on a further beat: saturate and set err_code[2].
  - line_cnt at all-ones on tlast: saturate and set err_code[2].
  - err_pulse fires once, on the cycle the bit first sets.
- Multiple errors in one frame: err_pulse fires once per newly set bit event; err_code accumulates.
- Sync and decimation:
  - On each SOF beat with enable = 1, div_cnt counts 0..SYNC_DIV-1.
  - sync_pulse = 1 on the cycle after the SOF beat when div_cnt was 0.
  - enable = 0: div_cnt holds and no pulse is emitted.
  - SYNC_DIV = 1: pulse on every SOF.
- Latency: sync_pulse, geometry outputs and err_pulse are all registered, 1 cycle after the qualifying beat.
- Back-to-back SOF beats: each produces its own pulse (subject to div). The second SOF reports frame_height = 0 and geom_valid = 0.

Test Plan:
- Reset, then 3 frames of 4 lines x 8 beats with random tvalid/tready gaps -> sync_pulse once per SOF, 1 cycle after the SOF beat. After SOF of frames 2 and 3: line_width = 8, frame_height = 4, geom_valid = 1, err_code = 0.
- Line 2 of 4 is 7 beats -> err_pulse at the tlast beat, err_code = 3'b001. Next SOF: geom_valid = 0, err_code cleared after the SOF.
- SOF arrives 3 beats into a line -> err_code[1] = 1 and err_pulse, then geom_valid = 0 at that SOF. A clean frame afterwards restores geom_valid = 1.
- SYNC_DIV = 3, 7 SOFs with enable = 1 -> pulses on SOFs 1, 4, 7. With enable = 0 for SOFs 2-3 -> pulses on 1, 6; geometry still updates.
- W_BITS = 3, 9-beat line -> px_cnt saturates, err_code[2] = 1, single err_pulse.
- resetn low mid-line in ACTIVE -> all outputs 0 immediately. Beats before the next SOF are ignored; the first SOF after reset gives sync_pulse and no geometry update.
